// File: rtl/gxb_reset_seq_pkg.sv
// Shared state encodings, default delays and output decode for the GXB reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gxb_reset_seq_pkg;

    // 3-bit state encodings
    localparam logic [2:0] ST_PWRDN     = 3'd0;
    localparam logic [2:0] ST_WAIT_PLL  = 3'd1;
    localparam logic [2:0] ST_TX_REL    = 3'd2;
    localparam logic [2:0] ST_WAIT_FREQ = 3'd3;
    localparam logic [2:0] ST_RX_DIG    = 3'd4;
    localparam logic [2:0] ST_READY     = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    // default delay constants (clk cycles)
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_PLL_TIMEOUT  = 20000;
    localparam int DEF_RX_ANA_HOLD  = 50;
    localparam int DEF_FREQ_STABLE  = 1000;
    localparam int DEF_RX_DIG_DELAY = 4000;
    localparam int DEF_MAX_RETRY    = 3;

    typedef enum logic [2:0] {
        S_PWRDN     = ST_PWRDN,
        S_WAIT_PLL  = ST_WAIT_PLL,
        S_TX_REL    = ST_TX_REL,
        S_WAIT_FREQ = ST_WAIT_FREQ,
        S_RX_DIG    = ST_RX_DIG,
        S_READY     = ST_READY,
        S_FAULT     = ST_FAULT
    } state_t;

    typedef struct packed {
        logic tx_rst;
        logic rx_ana_rst;
        logic rx_dig_rst;
        logic link_ready;
        logic fault;
    } out_t;

    localparam out_t OUT_RESET = '{tx_rst: 1'b1, rx_ana_rst: 1'b1, rx_dig_rst: 1'b1,
                                   link_ready: 1'b0, fault: 1'b0};

    // Output levels held while resident in a given state.
    function automatic out_t state_outputs(input state_t s);
        out_t o;
        o = OUT_RESET;
        case (s)
            S_TX_REL: o.tx_rst = 1'b0;
            S_WAIT_FREQ, S_RX_DIG: begin
                o.tx_rst     = 1'b0;
                o.rx_ana_rst = 1'b0;
            end
            S_READY: begin
                o.tx_rst     = 1'b0;
                o.rx_ana_rst = 1'b0;
                o.rx_dig_rst = 1'b0;
                o.link_ready = 1'b1;
            end
            S_FAULT: o.fault = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/gxb_reset_seq_bit_sync.sv
// 2-FF synchronizer for one asynchronous level into the clk domain.
// Latency: 2 clk cycles.
// Backpressure: none.
// Ports: clk, rst (sync active-high, clears both stages to 0), d (async in), q (synced out).
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gxb_reset_seq.sv
// Sequences GXB transceiver resets after powerdown: PLL lock, TX PCS, RX PMA, RX PCS, link_ready.
// Latency: outputs registered, updated on the edge of each state change; lock inputs add 2 cycles.
// Backpressure: none; loss of lock re-enters the sequence, repeated PLL timeouts latch fault.
// Ports: clk, sys_rst (sync active-high), gxb_pwrdn (sync level), pll_locked / rx_freqlocked (async),
//        tx_digitalreset, rx_analogreset, rx_digitalreset, link_ready, fault, retry_cnt[1:0].
module gxb_reset_seq
    import gxb_reset_seq_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int PLL_TIMEOUT  = DEF_PLL_TIMEOUT,
    parameter int RX_ANA_HOLD  = DEF_RX_ANA_HOLD,
    parameter int FREQ_STABLE  = DEF_FREQ_STABLE,
    parameter int RX_DIG_DELAY = DEF_RX_DIG_DELAY,
    parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       sys_rst,
    input  logic       gxb_pwrdn,
    input  logic       pll_locked,
    input  logic       rx_freqlocked,
    output logic       tx_digitalreset,
    output logic       rx_analogreset,
    output logic       rx_digitalreset,
    output logic       link_ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    // Terminal counts; every delay is an equality compare so the counter never wraps.
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ANA_LAST  = CNT_W'(RX_ANA_HOLD - 1);
    localparam logic [CNT_W-1:0] FREQ_LAST = CNT_W'(FREQ_STABLE - 1);
    localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(RX_DIG_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    logic             pll_locked_s;
    logic             rx_freqlocked_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       retry_nxt;
    out_t             outs;

    bit_sync u_pll_sync (
        .clk (clk),
        .rst (sys_rst),
        .d   (pll_locked),
        .q   (pll_locked_s)
    );

    bit_sync u_freq_sync (
        .clk (clk),
        .rst (sys_rst),
        .d   (rx_freqlocked),
        .q   (rx_freqlocked_s)
    );

    // Next state / counter. Ordering of the if-chains encodes event priority:
    // powerdown, then PLL loss, then freq loss, then counter expiry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        if (gxb_pwrdn) begin
            state_nxt = S_PWRDN;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                S_PWRDN: begin
                    state_nxt = S_WAIT_PLL;
                    cnt_nxt   = '0;
                end
                S_WAIT_PLL: begin
                    if (pll_locked_s) begin
                        state_nxt = S_TX_REL;
                        cnt_nxt   = '0;
                    end else if (cnt == PLL_LAST) begin
                        cnt_nxt = '0;
                        if (retry_cnt >= RETRY_MAX) state_nxt = S_FAULT;
                        else                        retry_nxt = retry_cnt + 2'd1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_TX_REL: begin
                    if (!pll_locked_s) begin
                        state_nxt = S_WAIT_PLL;
                        cnt_nxt   = '0;
                    end else if (cnt == ANA_LAST) begin
                        state_nxt = S_WAIT_FREQ;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_WAIT_FREQ: begin
                    // cnt measures an unbroken run of freq lock
                    if (!pll_locked_s) begin
                        state_nxt = S_WAIT_PLL;
                        cnt_nxt   = '0;
                    end else if (!rx_freqlocked_s) begin
                        cnt_nxt = '0;
                    end else if (cnt == FREQ_LAST) begin
                        state_nxt = S_RX_DIG;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_RX_DIG: begin
                    if (!pll_locked_s) begin
                        state_nxt = S_WAIT_PLL;
                        cnt_nxt   = '0;
                    end else if (!rx_freqlocked_s) begin
                        state_nxt = S_WAIT_FREQ;
                        cnt_nxt   = '0;
                    end else if (cnt == DIG_LAST) begin
                        state_nxt = S_READY;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                S_READY: begin
                    if (!pll_locked_s) begin
                        state_nxt = S_WAIT_PLL;
                        cnt_nxt   = '0;
                    end else if (!rx_freqlocked_s) begin
                        state_nxt = S_WAIT_FREQ;
                        cnt_nxt   = '0;
                    end
                end
                S_FAULT: cnt_nxt = '0;
                default: begin
                    state_nxt = S_PWRDN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered with it, so they
    // move on the same edge as the transition.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state     <= S_PWRDN;
            cnt       <= '0;
            retry_cnt <= '0;
            outs      <= OUT_RESET;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            retry_cnt <= retry_nxt;
            outs      <= state_outputs(state_nxt);
        end
    end

    assign tx_digitalreset = outs.tx_rst;
    assign rx_analogreset  = outs.rx_ana_rst;
    assign rx_digitalreset = outs.rx_dig_rst;
    assign link_ready      = outs.link_ready;
    assign fault           = outs.fault;

endmodule
